// File: rtl/dmem_requester.sv
// Core-side requester for the synchronous single-port data memory: load, store
// and forward block copy, with address-window checking at request acceptance.
module dmem_requester #(
    parameter int ADDR_LO = 64,
    parameter int ADDR_HI = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [6:0] req_len,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic [7:0] mem_address,
    output logic [7:0] mem_write_data,
    output logic       mem_write_enable,
    input  logic [7:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, LD_ISS, LD_CAP, ST_WR, CP_RD, CP_CAP, CP_WR, RESP} state_t;

    localparam logic [8:0] LO9 = 9'(ADDR_LO);
    localparam logic [8:0] HI9 = 9'(ADDR_HI);

    state_t     r_state, w_nstate;
    logic [7:0] r_src, r_dst, r_buf;
    logic [6:0] r_len, r_idx;

    logic [7:0] w_src, w_dst, w_buf, w_addr, w_wdata, w_rdata;
    logic [6:0] w_len, w_idx, w_idx_nx;
    logic       w_ready, w_rvalid, w_err, w_we, w_ok;
    logic [8:0] w_a9, w_d9, w_aend, w_dend;
    logic       w_ls_ok, w_cp_ok;

    // 9-bit sums so a copy that runs past address 255 cannot wrap into the window
    assign w_a9     = {1'b0, req_addr};
    assign w_d9     = {1'b0, req_wdata};
    assign w_aend   = w_a9 + {2'b00, req_len} - 9'd1;
    assign w_dend   = w_d9 + {2'b00, req_len} - 9'd1;
    assign w_ls_ok  = (w_a9 >= LO9) && (w_a9 <= HI9);
    assign w_cp_ok  = (w_a9 >= LO9) && (w_d9 >= LO9) &&
                      ((req_len == 7'd0) || ((w_aend <= HI9) && (w_dend <= HI9)));
    assign w_idx_nx = r_idx + 7'd1;

    always_comb begin
        w_nstate = r_state;
        w_ready  = req_ready;
        w_rvalid = resp_valid;
        w_rdata  = resp_rdata;
        w_err    = resp_err;
        w_addr   = mem_address;
        w_wdata  = mem_write_data;
        w_we     = 1'b0;
        w_src    = r_src;
        w_dst    = r_dst;
        w_len    = r_len;
        w_idx    = r_idx;
        w_buf    = r_buf;
        w_ok     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (req_valid) begin
                    w_ready = 1'b0;
                    w_src   = req_addr;
                    w_dst   = req_wdata;
                    w_len   = req_len;
                    w_idx   = 7'd0;
                    case (req_op)
                        2'b00:   w_ok = w_ls_ok;
                        2'b01:   w_ok = w_ls_ok;
                        2'b10:   w_ok = w_cp_ok;
                        default: w_ok = 1'b0;
                    endcase
                    if (!w_ok || (req_op == 2'b10 && req_len == 7'd0)) begin
                        w_nstate = RESP;
                        w_rvalid = 1'b1;
                        w_err    = !w_ok;
                        w_rdata  = 8'd0;
                    end else if (req_op == 2'b00) begin
                        w_nstate = LD_ISS;
                        w_addr   = req_addr;
                    end else if (req_op == 2'b01) begin
                        w_nstate = ST_WR;
                        w_addr   = req_addr;
                        w_wdata  = req_wdata;
                        w_we     = 1'b1;
                    end else begin
                        w_nstate = CP_RD;
                        w_addr   = req_addr;
                    end
                end
            end
            LD_ISS: w_nstate = LD_CAP;
            LD_CAP: begin
                w_nstate = RESP;
                w_rvalid = 1'b1;
                w_rdata  = mem_read_data;
                w_err    = 1'b0;
            end
            ST_WR: begin
                w_nstate = RESP;
                w_rvalid = 1'b1;
                w_rdata  = 8'd0;
                w_err    = 1'b0;
            end
            CP_RD: w_nstate = CP_CAP;
            CP_CAP: begin
                w_nstate = CP_WR;
                w_buf    = mem_read_data;
                w_addr   = r_dst + {1'b0, r_idx};
                w_wdata  = mem_read_data;
                w_we     = 1'b1;
            end
            CP_WR: begin
                w_idx = w_idx_nx;
                if (w_idx_nx == r_len) begin
                    w_nstate = RESP;
                    w_rvalid = 1'b1;
                    w_rdata  = r_buf;
                    w_err    = 1'b0;
                end else begin
                    w_nstate = CP_RD;
                    w_addr   = r_src + {1'b0, w_idx_nx};
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_nstate = IDLE;
                    w_rvalid = 1'b0;
                    w_ready  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 8'd0;
            resp_err         <= 1'b0;
            mem_address      <= 8'd0;
            mem_write_data   <= 8'd0;
            mem_write_enable <= 1'b0;
            r_src            <= 8'd0;
            r_dst            <= 8'd0;
            r_len            <= 7'd0;
            r_idx            <= 7'd0;
            r_buf            <= 8'd0;
        end else begin
            r_state          <= w_nstate;
            req_ready        <= w_ready;
            resp_valid       <= w_rvalid;
            resp_rdata       <= w_rdata;
            resp_err         <= w_err;
            mem_address      <= w_addr;
            mem_write_data   <= w_wdata;
            mem_write_enable <= w_we;
            r_src            <= w_src;
            r_dst            <= w_dst;
            r_len            <= w_len;
            r_idx            <= w_idx;
            r_buf            <= w_buf;
        end
    end

endmodule

// File: doc/dmem_requester.md
Name: dmem_requester

Overview:
- Initiator-side controller that drives the synchronous single-port data memory: mem_address, mem_write_data and mem_write_enable out, mem_read_data in.
- Accepts load, store and block-copy requests from the core over a valid/ready handshake.
- Sequences the memory's one-cycle registered read and enforces the legal data-address window.
- Returns one response per request, with data and an error flag.

Parameters:
- ADDR_LO, 64, lowest legal data address (inclusive).
- ADDR_HI, 127, highest legal data address (inclusive).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 load, 01 store, 10 copy, 11 reserved.
- req_addr  in  8  load/store address; copy source base.
- req_wdata  in  8  store data; copy destination base.
- req_len  in  7  copy byte count, 0..64; ignored for load/store.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  8  load data; for copy, the last byte copied.
- resp_err  out  1  request rejected; no memory access performed.
- mem_address  out  8  to memory data_address.
- mem_write_data  out  8  to memory write_data.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_data  in  8  from memory read_data, registered one edge after the address is presented with write_enable=0.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_address=0; mem_write_data=0; mem_write_enable=0. A copy interrupted by reset leaves memory partially written; there is no rollback.
- States: IDLE, LD_ISS, LD_CAP, ST_WR, CP_RD, CP_CAP, CP_WR, RESP.
- req_ready=1 only in IDLE. A request is accepted on an edge where req_valid and req_ready are both 1.
- Range check at acceptance, done in 9-bit arithmetic:
  - load/store: ADDR_LO <= req_addr <= ADDR_HI.
  - copy: both req_addr and req_wdata >= ADDR_LO, and base+req_len-1 <= ADDR_HI for each (skipped when req_len=0).
  - op 11 always fails.
  - On failure: go to RESP with resp_err=1 and resp_rdata=0. mem_write_enable stays 0.
- Load:
  - Accept edge E0 -> LD_ISS: mem_address=addr, we=0.
  - E1: memory samples the address -> LD_CAP.
  - E2: resp_rdata<=mem_read_data; resp_valid=1; -> RESP.
  - Latency is 2 cycles from acceptance to resp_valid.
- Store:
  - E0 -> ST_WR: mem_address=addr, mem_write_data=data, we=1.
  - E1: memory writes; we<=0; resp_valid=1; resp_rdata=0.
- Copy, forward byte order, index i=0..len-1, 3 cycles per byte:
  - CP_RD: mem_address=src+i, we=0.
  - CP_CAP: byte buffer <= mem_read_data at the end of the cycle; address held, we=0.
  - CP_WR: mem_address=dst+i, mem_write_data=buffer, we=1. Then i++. If i==len, go to RESP; otherwise go to CP_RD.
  - len=0: RESP one cycle after acceptance, resp_err=0, no memory access.
  - Overlapping regions with dst>src replicate source bytes. This is defined behaviour, not an error.
- RESP: resp_valid=1 until the edge where resp_ready=1, then IDLE with resp_valid=0.
  - A new request cannot be accepted in the same cycle as the response hand-off; req_ready rises the cycle after.
- mem_write_enable is 1 only in ST_WR and CP_WR, and is never asserted two consecutive cycles outside a copy.
- mem_address holds its last value when idle.

Test Plan:
- Store op=01, addr=70, wdata=0xA5, then load addr=70 -> mem_write_enable high exactly one cycle with mem_address=70; load resp_valid 2 cycles after acceptance with resp_rdata=0xA5 and resp_err=0.
- Load addr=63, then load addr=128, then store addr=200 -> each responds with resp_err=1; mem_write_enable never rises; memory contents unchanged.
- Preload 64..67 with 1,2,3,4; copy src=64, dst=100, len=4 -> locations 100..103 hold 1..4; resp_rdata=4; resp_valid 12 cycles after acceptance; exactly 4 write pulses.
- Copy src=120, dst=80, len=9 (source end 128) -> resp_err=1, zero memory accesses. Copy with len=0 -> resp_err=0 one cycle after acceptance.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 throughout; resp_ready=1 -> req_ready=1 on the next cycle.
- Assert rst during CP_WR of byte 2 of a len=4 copy -> all outputs go to reset values immediately; bytes 0..1 are written and bytes 2..3 are untouched; a subsequent load of byte 1's destination works normally.
